// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: state encoding, vector
// ordering and result field widths.
package truth_table_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } tts_state_e;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int TT_W        = 8;
    localparam int CNT_W       = 4;
    localparam int TMR_W       = 4;

    // Vector index bit positions: idx = {x,y,z}
    localparam int VEC_X_BIT   = 2;
    localparam int VEC_Y_BIT   = 1;
    localparam int VEC_Z_BIT   = 0;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter timing how long each stimulus vector is held.
module tt_settle_timer
    import truth_table_sequencer_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks {x,y,z} through all 8 vectors, captures F1..F3 after a settle time
// and checks the captured tables against the expected ones.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXP_F1        = 8'h00,
    parameter logic [7:0]  EXP_F2        = 8'h00,
    parameter logic [7:0]  EXP_F3        = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             x,
    output logic             y,
    output logic             z,
    input  logic             f1,
    input  logic             f2,
    input  logic             f3,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [TT_W-1:0]  tt_f1,
    output logic [TT_W-1:0]  tt_f2,
    output logic [TT_W-1:0]  tt_f3,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic             first_fail_valid
);

    tts_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx;
    logic             accept, sample, last, expired, mismatch;
    logic [CNT_W-1:0] mcnt_nxt;

    tt_settle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept | (sample & ~last)),
        .load_val (TMR_W'(SETTLE_CYCLES - 1)),
        .en       (state_q == ST_SETTLE),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        sample  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                accept  = 1'b1;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: if (expired) begin
                sample = 1'b1;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign last     = (idx == LAST_IDX);
    assign mismatch = (f1 != EXP_F1[idx]) | (f2 != EXP_F2[idx]) | (f3 != EXP_F3[idx]);
    assign mcnt_nxt = mismatch_cnt + {{(CNT_W-1){1'b0}}, mismatch};

    // idx returns to 0 at DONE entry so it can drive x,y,z directly.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            idx              <= '0;
            tt_f1            <= '0;
            tt_f2            <= '0;
            tt_f3            <= '0;
            mismatch_cnt     <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else if (sample) begin
            tt_f1[idx]   <= f1;
            tt_f2[idx]   <= f2;
            tt_f3[idx]   <= f3;
            mismatch_cnt <= mcnt_nxt;
            if (mismatch && !first_fail_valid) begin
                first_fail_idx   <= idx;
                first_fail_valid <= 1'b1;
            end
            if (last) begin
                idx  <= '0;
                pass <= (mcnt_nxt == '0);
            end else begin
                idx  <= idx + 1'b1;
            end
        end
    end

    assign x    = idx[VEC_X_BIT];
    assign y    = idx[VEC_Y_BIT];
    assign z    = idx[VEC_Z_BIT];
    assign busy = (state_q == ST_SETTLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Randomized self-checking bench: a stub circuit driven from per-run truth
// tables, checked against a table-level model of capture and comparison.
module tb_truth_table_sequencer;

    localparam int         SC = 2;
    localparam logic [7:0] E1 = 8'h96;
    localparam logic [7:0] E2 = 8'hC0;
    localparam logic [7:0] E3 = 8'hEE;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       x, y, z, f1, f2, f3;
    logic       busy, done, pass, first_fail_valid;
    logic [7:0] tt_f1, tt_f2, tt_f3;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_fail_idx;

    logic [7:0] st1, st2, st3;
    logic [7:0] g1, g2, g3;
    int         n_checks = 0;
    int         n_fail   = 0;

    truth_table_sequencer #(
        .SETTLE_CYCLES (SC),
        .EXP_F1        (E1),
        .EXP_F2        (E2),
        .EXP_F3        (E3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .x                (x),
        .y                (y),
        .z                (z),
        .f1               (f1),
        .f2               (f2),
        .f3               (f3),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .tt_f1            (tt_f1),
        .tt_f2            (tt_f2),
        .tt_f3            (tt_f3),
        .mismatch_cnt     (mismatch_cnt),
        .first_fail_idx   (first_fail_idx),
        .first_fail_valid (first_fail_valid)
    );

    always #5 clk = ~clk;

    // Stub circuit: output is the current run's table entry at vector {x,y,z}
    always_comb begin
        f1 = st1[{x, y, z}];
        f2 = st2[{x, y, z}];
        f3 = st3[{x, y, z}];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: correct circuit, 1: random faults, 2: all ones, 3: F2 wrong at vector 5
    task automatic set_stub(input int mode);
        logic [7:0] r1, r2, r3;
        r1 = ($urandom % 2) ? 8'($urandom) : 8'h00;
        r2 = ($urandom % 2) ? 8'($urandom) : 8'h00;
        r3 = ($urandom % 2) ? 8'($urandom) : 8'h00;
        case (mode)
            1:       begin st1 = g1 ^ r1; st2 = g2 ^ r2; st3 = g3 ^ r3; end
            2:       begin st1 = 8'hFF; st2 = 8'hFF; st3 = 8'hFF; end
            3:       begin st1 = g1; st2 = g2 ^ 8'h20; st3 = g3; end
            default: begin st1 = g1; st2 = g2; st3 = g3; end
        endcase
    endtask

    task automatic run(input bit hold, input bit mid_start);
        logic [7:0] m;
        int         ff, ecnt;
        m    = (st1 ^ E1) | (st2 ^ E2) | (st3 ^ E3);
        ecnt = $countones(m);
        ff   = -1;
        for (int i = 7; i >= 0; i--) if (m[i]) ff = i;

        if (!start) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;

        for (int k = 0; k < 8 * SC; k++) begin
            @(negedge clk);
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("vec_run", {x, y, z}, k / SC);
            if (k == 0)
                check("cleared", {tt_f1, tt_f2, tt_f3, mismatch_cnt, first_fail_valid, pass}, 0);
            if (mid_start && k == 3 * SC)     start = 1'b1;
            if (mid_start && k == 3 * SC + 1) start = 1'b0;
        end

        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("vec_done", {x, y, z}, 0);
        check("tt_f1", tt_f1, st1);
        check("tt_f2", tt_f2, st2);
        check("tt_f3", tt_f3, st3);
        check("mismatch_cnt", mismatch_cnt, ecnt);
        check("pass", pass, (ecnt == 0));
        check("ff_valid", first_fail_valid, (ff >= 0));
        if (ff >= 0) check("ff_idx", first_fail_idx, ff);

        @(negedge clk);
        check("done_low", done, 0);
        check("idle_gap", busy, 0);
        check("retain_tt", {tt_f1, tt_f2, tt_f3}, {st1, st2, st3});
        check("retain_cnt", mismatch_cnt, ecnt);
    endtask

    initial begin
        bit bad;
        for (int v = 0; v < 8; v++) begin
            g1[v] = (((v >> 2) ^ (v >> 1) ^ v) & 1) != 0;
            g2[v] = ((v >> 2) & (v >> 1) & 1) != 0;
            g3[v] = (((v >> 1) | v) & 1) != 0;
        end
        set_stub(0);
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {x, y, z, busy, done, pass, tt_f1, tt_f2, tt_f3,
                              mismatch_cnt, first_fail_idx, first_fail_valid}, 0);
        rst = 1'b0;

        set_stub(0); run(0, 0);
        set_stub(3); run(0, 0);
        set_stub(2); run(0, 0);
        set_stub(0); run(0, 1);

        // Back-to-back runs with start held high
        for (int r = 0; r < 3; r++) begin
            set_stub(r == 0 ? 2 : 1);
            run(1, 0);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while vector 4 is being applied
        set_stub(1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4 * SC + 1) @(negedge clk);
        check("vec_before_rst", {x, y, z}, 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_run", {x, y, z, busy, done, pass, tt_f1, tt_f2, tt_f3,
                              mismatch_cnt, first_fail_idx, first_fail_valid}, 0);
        rst = 1'b0;
        bad = 1'b0;
        repeat (10 * SC) begin
            @(negedge clk);
            if (done || busy) bad = 1'b1;
        end
        check("no_done_after_rst", bad, 0);

        for (int r = 0; r < 8; r++) begin
            set_stub(1);
            run(0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
